// File: rtl/program_sequencer_if.sv
// Byte handshake between program_sequencer (master) and the serial byte transmitter (slave).
// A byte moves on every cycle where tx_valid and tx_ready are both high.
interface program_sequencer_if;
   logic [7:0] tx_data;
   logic       tx_last;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_last, output tx_valid, input tx_ready);
   modport slave  (input tx_data, input tx_last, input tx_valid, output tx_ready);
endinterface

// File: rtl/program_sequencer.sv
// Glitch program sequencer: walks program_rom, sends bytes, waits table delays and drives glitch pulses.
// Optional macro SEQ_LOOP_EN: while start stays high, completion restarts the program at slot 0.
module program_sequencer #(
   parameter int PROG_LEN   = 14,
   parameter int NUM_DELAYS = 4,
   parameter int PTR_W      = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                abort,
   output logic [PTR_W-1:0]    instr_pt,
   input  logic [11:0]         instr,
   output logic [PTR_W-1:0]    delay_num,
   input  logic [31:0]         delay_len,
   program_sequencer_if.master tx,
   output logic                glitch_out,
   output logic                busy,
   output logic                done
);
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_SEND, S_DCAP, S_DELAY, S_PULSE, S_DONE
   } state_t;

   localparam logic [1:0]       OP_SEND  = 2'b00;
   localparam logic [1:0]       OP_PULSE = 2'b01;
   localparam logic [1:0]       OP_DELAY = 2'b10;
   localparam logic [1:0]       OP_HALT  = 2'b11;
   localparam logic [PTR_W-1:0] LAST_PT  = PTR_W'(PROG_LEN - 1);
   localparam logic [PTR_W-1:0] NUM_DLY  = PTR_W'(NUM_DELAYS);
   localparam logic [PTR_W-1:0] PT_ZERO  = {PTR_W{1'b0}};

   state_t           state_q, state_d;
   logic [PTR_W-1:0] pt_q, pt_d;
   logic [PTR_W-1:0] dnum_q, dnum_d;
   logic [31:0]      cnt_q, cnt_d;
   logic [7:0]       txd_q, txd_d;
   logic             txl_q, txl_d;
   logic             start_q;
   logic             txv_q, glitch_q, busy_q, done_q;

   logic [1:0]       op_s;
   logic [7:0]       arg_s;
   logic             eop_s;
   logic             last_slot_s;
   logic             dly_zero_s;
   state_t           adv_state_s;
   logic [PTR_W-1:0] adv_pt_s;

   assign op_s        = instr[11:10];
   assign arg_s       = instr[8:1];
   assign eop_s       = ~instr[9] | (op_s == OP_HALT);
   // Leaving the last slot is the same as reaching PROG_LEN, so go straight to DONE.
   assign last_slot_s = (pt_q == LAST_PT);
   assign adv_state_s = last_slot_s ? S_DONE : S_FETCH;
   assign adv_pt_s    = last_slot_s ? PT_ZERO : pt_q + PTR_W'(1);
   assign dly_zero_s  = (dnum_q >= NUM_DLY) | (delay_len == 32'd0);

   // Next-state and datapath decode.
   always_comb begin
      state_d = state_q;
      pt_d    = pt_q;
      dnum_d  = dnum_q;
      cnt_d   = cnt_q;
      txd_d   = txd_q;
      txl_d   = txl_q;
      if (abort && (state_q != S_IDLE)) begin
         state_d = S_IDLE;
         pt_d    = PT_ZERO;
         cnt_d   = 32'd0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && !start_q) begin
                  state_d = S_FETCH;
                  pt_d    = PT_ZERO;
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_FETCH: begin
               if (eop_s) begin
                  state_d = S_DONE;
                  pt_d    = PT_ZERO;
               end else begin
                  case (op_s)
                     OP_SEND: begin
                        txd_d   = arg_s;
                        txl_d   = instr[0];
                        state_d = S_SEND;
                     end
                     OP_DELAY: begin
                        dnum_d  = {{(PTR_W-8){1'b0}}, arg_s};
                        state_d = S_DCAP;
                     end
                     OP_PULSE: begin
                        if (arg_s != 8'd0) begin
                           cnt_d   = {24'd0, arg_s};
                           state_d = S_PULSE;
                        end else begin
                           state_d = adv_state_s;
                           pt_d    = adv_pt_s;
                        end
                     end
                     default: begin
                        state_d = S_DONE;
                        pt_d    = PT_ZERO;
                     end
                  endcase
               end
            end
            S_SEND: begin
               if (tx.tx_ready) begin
                  state_d = adv_state_s;
                  pt_d    = adv_pt_s;
               end else begin
                  state_d = S_SEND;
               end
            end
            S_DCAP: begin
               if (dly_zero_s) begin
                  state_d = adv_state_s;
                  pt_d    = adv_pt_s;
               end else begin
                  cnt_d   = delay_len;
                  state_d = S_DELAY;
               end
            end
            S_DELAY, S_PULSE: begin
               if (cnt_q == 32'd1) begin
                  cnt_d   = 32'd0;
                  state_d = adv_state_s;
                  pt_d    = adv_pt_s;
               end else begin
                  cnt_d   = cnt_q - 32'd1;
               end
            end
            S_DONE: begin
`ifdef SEQ_LOOP_EN
               if (start) begin
                  state_d = S_FETCH;
                  pt_d    = PT_ZERO;
               end else begin
                  state_d = S_IDLE;
               end
`else
               state_d = S_IDLE;
`endif
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State, datapath and registered outputs; outputs follow the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pt_q     <= PT_ZERO;
         dnum_q   <= PT_ZERO;
         cnt_q    <= 32'd0;
         txd_q    <= 8'd0;
         txl_q    <= 1'b0;
         start_q  <= 1'b1;
         txv_q    <= 1'b0;
         glitch_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pt_q     <= pt_d;
         dnum_q   <= dnum_d;
         cnt_q    <= cnt_d;
         txd_q    <= txd_d;
         txl_q    <= txl_d;
         start_q  <= start;
         txv_q    <= (state_d == S_SEND);
         glitch_q <= (state_d == S_PULSE);
         busy_q   <= (state_d != S_IDLE) && (state_d != S_DONE);
         done_q   <= (state_d == S_DONE);
      end
   end

   assign instr_pt    = pt_q;
   assign delay_num   = dnum_q;
   assign tx.tx_data  = txd_q;
   assign tx.tx_last  = txl_q;
   assign tx.tx_valid = txv_q;
   assign glitch_out  = glitch_q;
   assign busy        = busy_q;
   assign done        = done_q;
endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: ROM and delay table are modelled here, results are
// compared against a slot-by-slot program walk.
module tb_program_sequencer;
   localparam int         PROG_LEN = 14;
   localparam logic [1:0] OP_SEND  = 2'b00;
   localparam logic [1:0] OP_PULSE = 2'b01;
   localparam logic [1:0] OP_DELAY = 2'b10;
   localparam logic [1:0] OP_HALT  = 2'b11;

   logic        clk = 1'b0;
   logic        rst, start, abort;
   logic [7:0]  instr_pt, delay_num;
   logic [11:0] instr;
   logic [31:0] delay_len;
   logic        glitch_out, busy, done;
   logic [11:0] rom [PROG_LEN];
   logic [31:0] dtab [4];
   int          vectors = 0;
   int          miscompares = 0;

   program_sequencer_if tx_if ();

   program_sequencer dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .instr_pt(instr_pt), .instr(instr), .delay_num(delay_num), .delay_len(delay_len),
      .tx(tx_if), .glitch_out(glitch_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Out-of-range delay indices alias onto real entries so an unguarded index shows up.
   assign instr     = (instr_pt < 8'd14) ? rom[instr_pt[3:0]] : 12'h000;
   assign delay_len = dtab[delay_num[1:0]];

   logic [8:0] got_b [$];
   int         got_p [$];
   int         run_len, busy_cyc, done_cnt, stab_err;
   logic       mon_clr = 1'b1;
   logic       prev_stall;
   logic [8:0] prev_word;

   always @(negedge clk) begin
      #1;
      if (mon_clr) begin
         got_b.delete();
         got_p.delete();
         run_len    <= 0;
         busy_cyc   <= 0;
         done_cnt   <= 0;
         stab_err   <= 0;
         prev_stall <= 1'b0;
         prev_word  <= 9'd0;
      end else begin
         if (prev_stall && (!tx_if.tx_valid || {tx_if.tx_last, tx_if.tx_data} != prev_word))
            stab_err <= stab_err + 1;
         prev_stall <= tx_if.tx_valid && !tx_if.tx_ready;
         prev_word  <= {tx_if.tx_last, tx_if.tx_data};
         if (tx_if.tx_valid && tx_if.tx_ready) got_b.push_back({tx_if.tx_last, tx_if.tx_data});
         if (glitch_out) run_len <= run_len + 1;
         else if (run_len != 0) begin
            got_p.push_back(run_len);
            run_len <= 0;
         end
         if (busy) busy_cyc <= busy_cyc + 1;
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   logic [8:0] exp_b [$];
   int         exp_p [$];
   longint     exp_cyc;

   function automatic logic [11:0] mk(input logic [1:0] op, input logic v, input logic [7:0] a,
                                      input logic f);
      return {op, v, a, f};
   endfunction

   // Walk the program slot by slot with tx_ready assumed always high for the cycle total.
   task automatic model();
      logic [11:0] w;
      int a;
      exp_b.delete();
      exp_p.delete();
      exp_cyc = 0;
      for (int s = 0; s < PROG_LEN; s++) begin
         w = rom[s];
         a = int'(w[8:1]);
         if (!w[9] || w[11:10] == OP_HALT) begin
            exp_cyc += 1;
            break;
         end
         if (w[11:10] == OP_SEND) begin
            exp_b.push_back({w[0], w[8:1]});
            exp_cyc += 2;
         end else if (w[11:10] == OP_DELAY) begin
            exp_cyc += 2 + ((a < 4) ? longint'(dtab[a]) : 64'sd0);
         end else begin
            if (a > 0) exp_p.push_back(a);
            exp_cyc += 1 + a;
         end
      end
   endtask

   task automatic fill_halt();
      for (int s = 0; s < PROG_LEN; s++) rom[s] = mk(OP_HALT, 1'b1, 8'h00, 1'b0);
   endtask

   task automatic clr_mon();
      mon_clr = 1'b1;
      @(negedge clk);
      #2;
      mon_clr = 1'b0;
   endtask

   task automatic run_prog(input bit rnd_rdy, input int poke, input int maxc);
      clr_mon();
      tx_if.tx_ready = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         tx_if.tx_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
         start = (i == poke && busy) ? 1'b1 : 1'b0;
         if (done_cnt != 0) break;
      end
      start = 1'b0;
      tx_if.tx_ready = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      vectors++;
      if ({instr_pt, delay_num, tx_if.tx_data, tx_if.tx_last, tx_if.tx_valid, glitch_out, busy, done} !== 30'd0) begin
         miscompares++;
         $display("FAIL reset_outputs got %h expected 0", {instr_pt, delay_num, tx_if.tx_data,
                  tx_if.tx_last, tx_if.tx_valid, glitch_out, busy, done});
      end
      rst = 1'b0;
      repeat (5) @(negedge clk);
      vectors++;
      if (busy !== 1'b0 || instr_pt !== 8'd0) begin
         miscompares++;
         $display("FAIL start_high_from_reset busy %b instr_pt %0d expected 0 0", busy, instr_pt);
      end
      start = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_default();
      rom = '{mk(OP_SEND, 1'b1, 8'h84, 1'b0), mk(OP_SEND, 1'b1, 8'h01, 1'b0),
              mk(OP_SEND, 1'b1, 8'h0F, 1'b0), mk(OP_DELAY, 1'b1, 8'd0, 1'b0),
              mk(OP_PULSE, 1'b1, 8'd1, 1'b0), mk(OP_SEND, 1'b1, 8'h55, 1'b0),
              mk(OP_DELAY, 1'b1, 8'd1, 1'b0), mk(OP_PULSE, 1'b1, 8'd3, 1'b0),
              mk(OP_DELAY, 1'b1, 8'd7, 1'b0), mk(OP_PULSE, 1'b1, 8'd0, 1'b0),
              mk(OP_SEND, 1'b1, 8'hAA, 1'b0), mk(OP_DELAY, 1'b1, 8'd2, 1'b0),
              mk(OP_PULSE, 1'b1, 8'd2, 1'b0), mk(OP_SEND, 1'b1, 8'h80, 1'b1)};
      dtab = '{32'd8000, 32'd5, 32'd0, 32'h0402EAA0};
      model();
      run_prog(1'b0, -1, 9000);
      vectors++;
      if (done_cnt != 1) begin miscompares++; $display("FAIL dflt_done got %0d expected 1", done_cnt); end
      vectors++;
      if (busy_cyc != exp_cyc) begin miscompares++; $display("FAIL dflt_busy_cycles got %0d expected %0d", busy_cyc, exp_cyc); end
      vectors++;
      if (got_b.size() != exp_b.size()) begin
         miscompares++; $display("FAIL dflt_nbytes got %0d expected %0d", got_b.size(), exp_b.size());
      end else begin
         foreach (exp_b[i]) begin
            vectors++;
            if (got_b[i] !== exp_b[i]) begin miscompares++; $display("FAIL dflt_byte%0d got %h expected %h", i, got_b[i], exp_b[i]); end
         end
      end
      vectors++;
      if (got_p.size() != exp_p.size()) begin
         miscompares++; $display("FAIL dflt_npulses got %0d expected %0d", got_p.size(), exp_p.size());
      end else begin
         foreach (exp_p[i]) begin
            vectors++;
            if (got_p[i] != exp_p[i]) begin miscompares++; $display("FAIL dflt_pulse%0d got %0d expected %0d", i, got_p[i], exp_p[i]); end
         end
      end
   endtask

   task automatic test_backpressure();
      int k;
      fill_halt();
      rom[0] = mk(OP_SEND, 1'b1, 8'h84, 1'b0);
      clr_mon();
      tx_if.tx_ready = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      k = 0;
      while (!tx_if.tx_valid && k < 10) begin @(negedge clk); k++; end
      for (int c = 1; c <= 6; c++) begin
         vectors++;
         if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 8'h84) begin
            miscompares++;
            $display("FAIL bp_hold_cycle%0d valid %b data %h expected 1 84", c, tx_if.tx_valid, tx_if.tx_data);
         end
         if (c == 6) tx_if.tx_ready = 1'b1;
         else @(negedge clk);
      end
      @(negedge clk);
      vectors++;
      if (tx_if.tx_valid !== 1'b0) begin miscompares++; $display("FAIL bp_valid_drop got %b expected 0", tx_if.tx_valid); end
      repeat (4) @(negedge clk);
      vectors++;
      if (got_b.size() != 1 || stab_err != 0) begin
         miscompares++; $display("FAIL bp_accept_once got %0d bytes %0d unstable expected 1 0", got_b.size(), stab_err);
      end
      vectors++;
      if (busy_cyc != 8 || done_cnt != 1) begin
         miscompares++; $display("FAIL bp_timing busy %0d done %0d expected 8 1", busy_cyc, done_cnt);
      end
   endtask

   task automatic test_pulse();
      fill_halt();
      rom[0] = mk(OP_PULSE, 1'b1, 8'hFB, 1'b0);
      rom[1] = mk(OP_PULSE, 1'b1, 8'h00, 1'b0);
      run_prog(1'b0, -1, 600);
      vectors++;
      if (got_p.size() != 1 || got_p[0] != 251) begin
         miscompares++; $display("FAIL pulse_251 runs %0d first %0d expected 1 251", got_p.size(), got_p[0]);
      end
      vectors++;
      if (busy_cyc != 254 || done_cnt != 1) begin
         miscompares++; $display("FAIL pulse_timing busy %0d done %0d expected 254 1", busy_cyc, done_cnt);
      end
   endtask

   task automatic test_delay_oob();
      fill_halt();
      rom[0] = mk(OP_DELAY, 1'b1, 8'd7, 1'b0);
      rom[1] = mk(OP_SEND, 1'b1, 8'h11, 1'b0);
      dtab = '{32'd8000, 32'd5, 32'd0, 32'h0402EAA0};
      run_prog(1'b0, -1, 300);
      vectors++;
      if (busy_cyc != 5 || done_cnt != 1) begin
         miscompares++; $display("FAIL delay_oob_timing busy %0d done %0d expected 5 1", busy_cyc, done_cnt);
      end
      vectors++;
      if (got_b.size() != 1 || got_b[0] !== 9'h011) begin
         miscompares++; $display("FAIL delay_oob_byte count %0d first %h expected 1 011", got_b.size(), got_b[0]);
      end
   endtask

   task automatic test_abort();
      fill_halt();
      rom[0] = mk(OP_SEND, 1'b1, 8'h21, 1'b0);
      rom[1] = mk(OP_DELAY, 1'b1, 8'd3, 1'b0);
      rom[2] = mk(OP_SEND, 1'b1, 8'h22, 1'b0);
      dtab = '{32'd8000, 32'd5, 32'd0, 32'h0402EAA0};
      clr_mon();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      vectors++;
      if (busy !== 1'b1 || delay_num !== 8'd3) begin
         miscompares++; $display("FAIL abort_in_delay busy %b delay_num %0d expected 1 3", busy, delay_num);
      end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      vectors++;
      if ({busy, tx_if.tx_valid, glitch_out, done} !== 4'b0000) begin
         miscompares++; $display("FAIL abort_delay_idle got %b expected 0000", {busy, tx_if.tx_valid, glitch_out, done});
      end
      repeat (10) @(negedge clk);
      vectors++;
      if (done_cnt != 0 || got_b.size() != 1 || got_b[0] !== 9'h021) begin
         miscompares++; $display("FAIL abort_delay_result done %0d bytes %0d expected 0 1", done_cnt, got_b.size());
      end
      fill_halt();
      rom[0] = mk(OP_PULSE, 1'b1, 8'hFB, 1'b0);
      clr_mon();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      vectors++;
      if ({busy, glitch_out} !== 2'b00) begin
         miscompares++; $display("FAIL abort_pulse got busy/glitch %b expected 00", {busy, glitch_out});
      end
      repeat (5) @(negedge clk);
      vectors++;
      if (done_cnt != 0) begin miscompares++; $display("FAIL abort_pulse_done got %0d expected 0", done_cnt); end
   endtask

   task automatic test_reset_pulse();
      fill_halt();
      rom[0] = mk(OP_PULSE, 1'b1, 8'hFB, 1'b0);
      clr_mon();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      vectors++;
      if (glitch_out !== 1'b1) begin miscompares++; $display("FAIL rst_pulse_pre got %b expected 1", glitch_out); end
      #3 rst = 1'b1;
      #1;
      vectors++;
      if ({glitch_out, busy, instr_pt} !== 10'd0) begin
         miscompares++; $display("FAIL rst_async_clear got %h expected 0", {glitch_out, busy, instr_pt});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_after_release busy %b expected 0", busy); end
   endtask

   task automatic test_start_hold();
      int k;
      fill_halt();
      rom[0] = mk(OP_SEND, 1'b1, 8'h84, 1'b0);
      clr_mon();
      start = 1'b1;
`ifdef SEQ_LOOP_EN
      k = 0;
      while (done_cnt < 2 && k < 200) begin @(negedge clk); k++; end
      start = 1'b0;
      repeat (20) @(negedge clk);
      vectors++;
      if (done_cnt < 2 || got_b.size() != done_cnt || got_b[1] !== 9'h084) begin
         miscompares++; $display("FAIL loop_passes done %0d bytes %0d expected >=2 equal", done_cnt, got_b.size());
      end
`else
      for (k = 0; k < 60; k++) @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      vectors++;
      if (done_cnt != 1 || got_b.size() != 1) begin
         miscompares++; $display("FAIL hold_single_pass done %0d bytes %0d expected 1 1", done_cnt, got_b.size());
      end
`endif
      vectors++;
      if (busy !== 1'b0) begin miscompares++; $display("FAIL hold_end_idle busy %b expected 0", busy); end
   endtask

   task automatic test_random();
      int r;
      bit rnd;
      for (int it = 0; it < 20; it++) begin
         rnd = it[0];
         for (int d = 0; d < 4; d++) dtab[d] = 32'($urandom_range(0, 20));
         for (int s = 0; s < PROG_LEN; s++) begin
            r = $urandom_range(0, 19);
            if (r < 8)       rom[s] = mk(OP_SEND, 1'b1, 8'($urandom), 1'($urandom));
            else if (r < 12) rom[s] = mk(OP_DELAY, 1'b1, 8'($urandom_range(0, 7)), 1'b0);
            else if (r < 17) rom[s] = mk(OP_PULSE, 1'b1, 8'($urandom_range(0, 12)), 1'b0);
            else if (r < 18) rom[s] = mk(OP_HALT, 1'b1, 8'($urandom), 1'b0);
            else if (r < 19) rom[s] = mk(2'($urandom), 1'b0, 8'($urandom), 1'b0);
            else             rom[s] = mk(OP_SEND, 1'b1, 8'($urandom), 1'b1);
         end
         model();
         run_prog(rnd, $urandom_range(2, 30), 4000);
         vectors++;
         if (done_cnt != 1 || stab_err != 0) begin
            miscompares++; $display("FAIL rnd%0d_done done %0d unstable %0d expected 1 0", it, done_cnt, stab_err);
         end
         vectors++;
         if (!rnd && busy_cyc != exp_cyc) begin
            miscompares++; $display("FAIL rnd%0d_busy got %0d expected %0d", it, busy_cyc, exp_cyc);
         end
         vectors++;
         if (got_b.size() != exp_b.size()) begin
            miscompares++; $display("FAIL rnd%0d_nbytes got %0d expected %0d", it, got_b.size(), exp_b.size());
         end else begin
            foreach (exp_b[i]) if (got_b[i] !== exp_b[i]) begin
               miscompares++; $display("FAIL rnd%0d_byte%0d got %h expected %h", it, i, got_b[i], exp_b[i]);
            end
         end
         vectors++;
         if (got_p.size() != exp_p.size()) begin
            miscompares++; $display("FAIL rnd%0d_npulses got %0d expected %0d", it, got_p.size(), exp_p.size());
         end else begin
            foreach (exp_p[i]) if (got_p[i] != exp_p[i]) begin
               miscompares++; $display("FAIL rnd%0d_pulse%0d got %0d expected %0d", it, i, got_p[i], exp_p[i]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b1;
      abort = 1'b0;
      tx_if.tx_ready = 1'b1;
      fill_halt();
      dtab = '{32'd0, 32'd0, 32'd0, 32'd0};
      test_reset();
      test_default();
      test_backpressure();
      test_pulse();
      test_delay_oob();
      test_abort();
      test_reset_pulse();
      test_start_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
Executes the glitch program held in program_rom. Walks instr_pt, decodes each 12-bit instruction and acts on it. SEND bytes go to the serial byte transmitter over a valid/ready handshake. DELAY waits a number of cycles taken from the delay table, and PULSE drives the glitch output. Sits between the top-level trigger logic and program_rom/transmitter; program_rom is purely combinational.

Parameters:
PROG_LEN, 14, number of instruction slots; instr_pt never exceeds PROG_LEN-1
NUM_DELAYS, 4, delay table entries; DELAY index >= NUM_DELAYS treated as zero-length delay
PTR_W, 8, width of instr_pt and delay_num

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
start  input  1  level; rising edge in IDLE launches program at slot 0
abort  input  1  synchronous abort, returns to IDLE next cycle
instr_pt  output  PTR_W  ROM address
instr  input  12  ROM data, valid same cycle as instr_pt
delay_num  output  PTR_W  delay table address
delay_len  input  32  delay table data, valid same cycle
tx_data  output  8  byte to transmitter
tx_last  output  1  frame-end flag accompanying tx_data
tx_valid  output  1  byte offered
tx_ready  input  1  transmitter accepts when tx_valid&tx_ready
glitch_out  output  1  glitch pulse
busy  output  1  high outside IDLE/DONE
done  output  1  one-cycle strobe on normal program completion

Behaviour:
- Reset: clk and rst are the only clock/reset. Asynchronous, active-high reset. State=IDLE; instr_pt=0, delay_num=0, tx_data=0, tx_last=0, tx_valid=0, glitch_out=0, busy=0, done=0; all counters 0.
- Instruction format: [11:10] op, [9] valid, [8:1] arg, [0] flag. A word with valid=0, or instr_pt reaching PROG_LEN, is end-of-program.
- Ops:
  - 00 SEND: tx_data=arg, tx_last=flag.
  - 10 DELAY: delay_num=arg.
  - 01 PULSE: glitch_out high for arg cycles.
  - 11 HALT: end-of-program.
- States: IDLE, FETCH, SEND, DELAY, PULSE, DONE.
- IDLE: start rising edge (registered previous value) -> FETCH with instr_pt=0. start held high from reset does not launch.
- FETCH (1 cycle): decode instr.
  - End-of-program -> DONE.
  - SEND -> load tx_data/tx_last, tx_valid=1, -> SEND.
  - DELAY -> delay_num=arg; next cycle capture delay_len into 32-bit down-counter -> DELAY.
  - PULSE -> load 8-bit counter=arg -> PULSE.
- SEND: hold tx_valid/tx_data/tx_last stable until tx_ready. Handshake cycle: tx_valid drops next cycle, instr_pt+1, -> FETCH. tx_ready high in the first SEND cycle completes in 1 cycle.
- DELAY: exactly delay_len cycles in DELAY state, then instr_pt+1 -> FETCH. delay_len=0 or index>=NUM_DELAYS: zero DELAY cycles, straight to FETCH. 32-bit count, no saturation issue (max 2^32-1).
- PULSE: glitch_out=1 for exactly arg consecutive cycles, registered output, no glitches. arg=0: no pulse, advance. Then instr_pt+1 -> FETCH.
- DONE: done=1 for one cycle, busy=0, -> IDLE. instr_pt returns to 0.
- abort (any state except IDLE): next cycle IDLE; tx_valid=0, glitch_out=0, counters cleared, done not asserted. An in-flight byte is dropped; abort coinciding with handshake still counts the byte as sent but no further fetch.
- start edge while busy is ignored.
- Reset mid-operation: immediate return to reset values, including glitch_out low asynchronously.

Optional Feature:
SEQ_LOOP_EN. Defined: at end-of-program, if start is high, done strobes and the sequencer re-enters FETCH at instr_pt=0 without passing IDLE (one-cycle DONE between passes). start low -> IDLE as normal. Undefined: end-of-program always -> DONE -> IDLE; another pass needs a new start edge.

Test Plan:
- Default ROM, tx_ready always 1, start pulse -> bytes 0x84,0x01,0x0F then stall 8000 cycles (delay 0), glitch 1 cycle, ..., done after slot 13; tx_last=1 only on byte 0x80.
- tx_ready held low 5 cycles on byte 0x84 -> tx_valid/tx_data=0x84 stable for 6 cycles, byte accepted exactly once.
- ROM with PULSE arg=0xFB -> glitch_out high exactly 251 consecutive cycles. PULSE arg=0 -> no high cycle.
- DELAY index 7 (>=NUM_DELAYS, delay_len=0) -> FETCH of next slot directly after the capture cycle, no DELAY cycles.
- abort during delay 3 (0x0402EAA0) -> IDLE next cycle, busy=0, done never asserted. Reset asserted during PULSE -> glitch_out low without a clock edge.
- SEQ_LOOP_EN with start held high -> second pass restarts at slot 0, byte 0x84 re-sent, done strobes once per pass.
